// File: rtl/dphy_pkg.sv
// dphy_pkg: shared state encoding, sync byte and LP pin levels for the D-PHY lane sequencer
package dphy_pkg;
  typedef enum logic [2:0] {IDLE, LPX, PREPARE, HS_ZERO, SYNC, DATA, TRAIL, EXIT} state_e;
  localparam logic [7:0] C_DPHY_SYNC_BYTE = 8'hB8;
  localparam logic [1:0] C_LP11 = 2'b11;
  localparam logic [1:0] C_LP01 = 2'b01;
  localparam logic [1:0] C_LP00 = 2'b00;
endpackage

// File: rtl/dphy_lane_hs_seq_if.sv
// dphy_lane_hs_seq_if: upstream byte stream (valid/ready with last marker) into the lane sequencer
interface dphy_lane_hs_seq_if;
  logic       valid_i;
  logic [7:0] d_i;
  logic       last_i;
  logic       ready_o;
  modport master (output valid_i, d_i, last_i, input ready_o);
  modport slave (input valid_i, d_i, last_i, output ready_o);
endinterface

// File: rtl/dphy_seq_timer.sv
// dphy_seq_timer: 8-bit loadable down-counter with zero flag, shared by all timed states
module dphy_seq_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] val_i,
  output logic       zero_o
);
  logic [7:0] cnt_q;
  always_ff @(posedge clk_i)
    cnt_q <= rst_i ? 8'd0 : load_i ? val_i : cnt_q - 8'(cnt_q != 8'd0);
  assign zero_o = cnt_q == 8'd0;
endmodule

// File: rtl/dphy_lane_hs_seq.sv
// dphy_lane_hs_seq: D-PHY lane LP->HS->LP burst sequencer; DPHY_LANE_SEQ_STATS_EN adds burst/underrun counters
module dphy_lane_hs_seq
  import dphy_pkg::*;
#(
  parameter int g_t_lpx        = 4,
  parameter int g_t_hs_prepare = 3,
  parameter int g_t_hs_zero    = 6,
  parameter int g_t_hs_trail   = 4,
  parameter int g_t_hs_exit    = 8
) (
  input  logic       clk_word_i,
  input  logic       rst_i,
  dphy_lane_hs_seq_if.slave up,
  output logic [7:0] hs_d_o,
  output logic       hs_tristate_o,
  output logic       lp_p_o,
  output logic       lp_n_o,
  output logic       busy_o,
  output logic       underrun_o
`ifdef DPHY_LANE_SEQ_STATS_EN
  ,
  output logic [15:0] burst_cnt_o,
  output logic [7:0]  underrun_cnt_o
`endif
);
  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_LPX     = LPX;
  localparam logic [2:0] S_PREPARE = PREPARE;
  localparam logic [2:0] S_HS_ZERO = HS_ZERO;
  localparam logic [2:0] S_SYNC    = SYNC;
  localparam logic [2:0] S_DATA    = DATA;
  localparam logic [2:0] S_TRAIL   = TRAIL;
  localparam logic [2:0] S_EXIT    = EXIT;
  logic [2:0] state_q, state_d;
  logic [7:0] hs_d_q, hs_d_d, tmr_val;
  logic [1:0] lp_q, lp_d;
  logic ready_q, ready_d, tri_q, tri_d, busy_q, busy_d, und_q, und_d, tmr_zero;
  dphy_seq_timer u_timer (
    .clk_i  (clk_word_i),
    .rst_i  (rst_i),
    .load_i (state_d != state_q),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = up.valid_i ? S_LPX : S_IDLE;
      S_LPX:     state_d = tmr_zero ? S_PREPARE : S_LPX;
      S_PREPARE: state_d = tmr_zero ? S_HS_ZERO : S_PREPARE;
      S_HS_ZERO: state_d = tmr_zero ? S_SYNC : S_HS_ZERO;
      S_SYNC, S_DATA: state_d = ready_q && up.valid_i ? S_DATA : S_TRAIL;
      S_TRAIL:   state_d = tmr_zero ? S_EXIT : S_TRAIL;
      default:   state_d = tmr_zero ? S_IDLE : S_EXIT;
    endcase
  end
  // DATA is only ever entered on a transfer, so d_i is always the byte to show next
  always_comb begin
    tmr_val = state_d == S_LPX     ? 8'(g_t_lpx - 1) :
              state_d == S_PREPARE ? 8'(g_t_hs_prepare - 1) :
              state_d == S_HS_ZERO ? 8'(g_t_hs_zero - 1) :
              state_d == S_TRAIL   ? 8'(g_t_hs_trail - 1) :
              state_d == S_EXIT    ? 8'(g_t_hs_exit - 1) : 8'd0;
    ready_d = state_d == S_SYNC || (state_d == S_DATA && !up.last_i);
    hs_d_d  = state_d == S_SYNC  ? C_DPHY_SYNC_BYTE :
              state_d == S_DATA  ? up.d_i :
              state_d == S_TRAIL ? (state_q == S_TRAIL ? hs_d_q : {8{~hs_d_q[7]}}) : 8'h00;
    tri_d   = state_d inside {S_IDLE, S_LPX, S_PREPARE, S_EXIT};
    lp_d    = state_d == S_LPX ? C_LP01 : state_d inside {S_IDLE, S_EXIT} ? C_LP11 : C_LP00;
    busy_d  = state_d != S_IDLE;
    und_d   = ready_q && !up.valid_i;
  end
  always_ff @(posedge clk_word_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      hs_d_q  <= 8'h00;
      tri_q   <= 1'b1;
      lp_q    <= C_LP11;
      busy_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      hs_d_q  <= hs_d_d;
      tri_q   <= tri_d;
      lp_q    <= lp_d;
      busy_q  <= busy_d;
      und_q   <= und_d;
    end
  end
  assign up.ready_o      = ready_q;
  assign hs_d_o          = hs_d_q;
  assign hs_tristate_o   = tri_q;
  assign {lp_p_o, lp_n_o} = lp_q;
  assign busy_o          = busy_q;
  assign underrun_o      = und_q;
`ifdef DPHY_LANE_SEQ_STATS_EN
  logic [15:0] burst_cnt_q;
  logic [7:0]  und_cnt_q;
  always_ff @(posedge clk_word_i) begin
    if (rst_i) begin
      burst_cnt_q <= 16'd0;
      und_cnt_q   <= 8'd0;
    end else begin
      if (state_q == S_SYNC && state_d == S_DATA) burst_cnt_q <= burst_cnt_q + 16'd1;
      if (und_d && und_cnt_q != 8'hFF) und_cnt_q <= und_cnt_q + 8'd1;
    end
  end
  assign burst_cnt_o    = burst_cnt_q;
  assign underrun_cnt_o = und_cnt_q;
`endif
endmodule

// File: tb/tb_dphy_lane_hs_seq.sv
// tb_dphy_lane_hs_seq: directed cycle-by-cycle check of the lane sequencer outputs
module tb_dphy_lane_hs_seq;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  dphy_lane_hs_seq_if up ();
  logic [7:0] hs_d;
  logic tri_s, lp_p, lp_n, busy, und;
`ifdef DPHY_LANE_SEQ_STATS_EN
  logic [15:0] bc;
  logic [7:0]  uc;
`endif
  dphy_lane_hs_seq dut (
    .clk_word_i    (clk),
    .rst_i         (rst),
    .up            (up.slave),
    .hs_d_o        (hs_d),
    .hs_tristate_o (tri_s),
    .lp_p_o        (lp_p),
    .lp_n_o        (lp_n),
    .busy_o        (busy),
    .underrun_o    (und)
`ifdef DPHY_LANE_SEQ_STATS_EN
    ,
    .burst_cnt_o    (bc),
    .underrun_cnt_o (uc)
`endif
  );
  int checks = 0, errors = 0;
  logic [13:0] obs;
  // {lp_p, lp_n, tristate, busy, ready, underrun, hs_d}
  assign obs = {lp_p, lp_n, tri_s, busy, up.ready_o, und, hs_d};
  localparam logic [13:0] IDLE_E = {2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
  localparam logic [13:0] LPX_E  = {2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
  localparam logic [13:0] PREP_E = {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
  localparam logic [13:0] ZERO_E = {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
  localparam logic [13:0] SYNC_E = {2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB8};
  localparam logic [13:0] EXIT_E = {2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
  function automatic logic [13:0] data_e(input logic [7:0] b, input logic r);
    return {2'b00, 1'b0, 1'b1, r, 1'b0, b};
  endfunction
  function automatic logic [13:0] trail_e(input logic [7:0] b, input logic u);
    return {2'b00, 1'b0, 1'b1, 1'b0, u, b};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask
  task automatic step(input string tag, input logic [13:0] x);
    @(posedge clk);
    #1;
    chk(tag, 32'(obs), 32'(x));
  endtask
  task automatic steps(input string tag, input int n, input logic [13:0] x);
    for (int i = 0; i < n; i++) step(tag, x);
  endtask
  task automatic preamble();
    steps("lpx", 4, LPX_E);
    steps("prepare", 3, PREP_E);
    steps("hs_zero", 6, ZERO_E);
    step("sync", SYNC_E);
  endtask
  task automatic finish_burst(input logic [7:0] t, input int n);
    steps("trail", n, trail_e(t, 1'b0));
    steps("exit", 8, EXIT_E);
    step("idle", IDLE_E);
  endtask
  initial begin
    up.valid_i = 1'b0;
    up.d_i = 8'h00;
    up.last_i = 1'b0;
    steps("reset", 3, IDLE_E);
    rst = 1'b0;
    steps("post_reset", 5, IDLE_E);
`ifdef DPHY_LANE_SEQ_STATS_EN
    chk("stats_reset", {16'(bc), 8'(uc)}, 32'h0);
`endif
    up.valid_i = 1'b1; up.d_i = 8'h11;
    preamble();
    step("nom_d11", data_e(8'h11, 1'b1));
    up.d_i = 8'h22;
    step("nom_d22", data_e(8'h22, 1'b1));
    up.d_i = 8'h33; up.last_i = 1'b1;
    step("nom_d33", data_e(8'h33, 1'b0));
    up.valid_i = 1'b0; up.last_i = 1'b0;
    finish_burst(8'hFF, 4);
    up.valid_i = 1'b1; up.d_i = 8'h80; up.last_i = 1'b1;
    preamble();
    step("one_d80", data_e(8'h80, 1'b0));
    up.valid_i = 1'b0; up.last_i = 1'b0;
    finish_burst(8'h00, 4);
    up.valid_i = 1'b1; up.d_i = 8'hAA;
    preamble();
    step("und_dAA", data_e(8'hAA, 1'b1));
    up.valid_i = 1'b0;
    step("und_pulse", trail_e(8'h00, 1'b1));
    finish_burst(8'h00, 3);
`ifdef DPHY_LANE_SEQ_STATS_EN
    chk("stats_3", {16'(bc), 8'(uc)}, {8'h0, 16'd3, 8'd1});
`endif
    up.valid_i = 1'b1; up.d_i = 8'h55;
    steps("mr_lpx", 4, LPX_E);
    steps("mr_prep", 3, PREP_E);
    steps("mr_zero", 2, ZERO_E);
    rst = 1'b1;
    step("mid_reset", IDLE_E);
    rst = 1'b0; up.valid_i = 1'b0;
    steps("after_reset", 4, IDLE_E);
    up.valid_i = 1'b1; up.d_i = 8'h01; up.last_i = 1'b1;
    preamble();
    step("b2b_d01", data_e(8'h01, 1'b0));
    steps("b2b_trail", 4, trail_e(8'hFF, 1'b0));
    steps("b2b_exit", 8, EXIT_E);
    step("b2b_idle", IDLE_E);
    preamble();
    step("b2b2_d01", data_e(8'h01, 1'b0));
    up.valid_i = 1'b0; up.last_i = 1'b0;
    finish_burst(8'hFF, 4);
`ifdef DPHY_LANE_SEQ_STATS_EN
    chk("stats_b2b", {16'(bc), 8'(uc)}, {8'h0, 16'd2, 8'd0});
`endif
    steps("final_idle", 3, IDLE_E);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
